// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;

  // One-hot vector with bit idx set.
  function automatic logic [NUM_REQ-1:0] onehot(sel_t idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning start_i, start_i+1, ... (mod 4).
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  sel_t               start_i,
  output sel_t               winner_o,
  output logic               any_req_o
);

  // Scan from the farthest offset down so the nearest set request is assigned last and wins.
  always_comb begin
    winner_o  = start_i;
    any_req_o = |req_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[sel_t'(start_i + sel_t'(i))]) begin
        winner_o = sel_t'(start_i + sel_t'(i));
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 single-bit mux.
// Optional feature macro: MUX4_ARB_LOCK_EN adds a lock input that suppresses the
// MAX_HOLD timeout while a grant is held.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic         a,
  input  logic         b,
  input  logic         c,
  input  logic         d,
`ifdef MUX4_ARB_LOCK_EN
  input  logic         lock,
`endif
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic         y,
  output logic         busy
);

  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t MaxHold = cnt_t'(MAX_HOLD);

  arb_state_t         state_q, state_d;
  sel_t               owner_q, owner_d;
  sel_t               last_q, last_d;
  cnt_t               hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  sel_t               sel_q, sel_d;
  logic               busy_q, busy_d;

  sel_t               pick_start;
  sel_t               pick_win;
  logic               pick_any;
  logic               others;
  logic               timeout;
  logic               release_gnt;
  logic [3:0]         data;

  // In GRANT last_q equals owner_q, so one picker serves both the idle pick and the re-pick.
  assign pick_start = sel_t'(last_q + sel_t'(1));

  rr_pick4 u_pick (
    .req_i     (req),
    .start_i   (pick_start),
    .winner_o  (pick_win),
    .any_req_o (pick_any)
  );

  // Release conditions for the current owner.
  always_comb begin
    others  = |(req & ~onehot(owner_q));
    timeout = (hold_q == MaxHold) && others;
`ifdef MUX4_ARB_LOCK_EN
    if (lock) begin
      timeout = 1'b0;
    end
`endif
    release_gnt = ~req[owner_q] | timeout;
  end

  // Next-state: grant, hold, re-grant on release, or fall back to idle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          owner_d = pick_win;
          last_d  = pick_win;
          hold_d  = cnt_t'(1);
          gnt_d   = onehot(pick_win);
          sel_d   = pick_win;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (release_gnt) begin
          if (pick_any) begin
            owner_d = pick_win;
            last_d  = pick_win;
            hold_d  = cnt_t'(1);
            gnt_d   = onehot(pick_win);
            sel_d   = pick_win;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (hold_q != MaxHold) begin
          hold_d = hold_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; last=3 gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= sel_t'(3);
      hold_q  <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign data = {d, c, b, a};

  // Unregistered data path: forward the selected bit only while a grant is held.
  always_comb begin
    y = 1'b0;
    if (busy_q) begin
      y = data[sel_q];
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus random traffic,
// compared against a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
`ifdef MUX4_ARB_LOCK_EN
  logic       lock = 1'b0;
`endif
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model state as plain integers.
  int m_busy = 0, m_sel = 0, m_owner = 0, m_last = 3, m_hold = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
`ifdef MUX4_ARB_LOCK_EN
    .lock (lock),
`endif
    .gnt  (gnt),
    .sel  (sel),
    .y    (y),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_gnt();
    logic [3:0] v;
    v = '0;
    if (m_busy != 0) v[m_owner] = 1'b1;
    return v;
  endfunction

  function automatic logic m_y();
    logic [3:0] dv;
    dv = {d, c, b, a};
    return (m_busy != 0) ? dv[m_sel] : 1'b0;
  endfunction

  task automatic m_grant(input int p);
    m_owner = p; m_sel = p; m_last = p; m_busy = 1; m_hold = 1;
  endtask

  task automatic model_edge();
    logic others;
    if (rst) begin
      m_busy = 0; m_sel = 0; m_owner = 0; m_last = 3; m_hold = 0;
    end else if (m_busy == 0) begin
      if (req != 0) m_grant(pick(m_last + 1, req));
    end else begin
      others = (req & ~(4'b0001 << m_owner)) != 0;
      if (!req[m_owner] || (m_hold == MH && others)) begin
        if (req != 0) m_grant(pick(m_owner + 1, req));
        else m_busy = 0;
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end
  endtask

  // One clock: check comb y against freshly driven data, advance, check registered outputs.
  task automatic tick();
    #1;
    chk("y_comb", {3'b0, y}, {3'b0, m_y()});
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt", gnt, m_gnt());
    chk("sel", {2'b0, sel}, 4'(m_sel));
    chk("busy", {3'b0, busy}, 4'(m_busy));
    chk("y", {3'b0, y}, {3'b0, m_y()});
  endtask

  initial begin
    logic [3:0] exp_g;

    // Reset
    rst = 1'b1; req = '0;
    tick(); tick();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_sel", {2'b0, sel}, 4'd0);
    chk("rst_y", {3'b0, y}, 4'd0);
    rst = 1'b0;
    tick();

    // All requesting: rotation 0,1,2,3,0 with MH cycles each
    req = 4'b1111; a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_g = '0;
      exp_g[(k / MH) % 4] = 1'b1;
      chk("rr_seq", gnt, exp_g);
      chk("rr_busy", {3'b0, busy}, 4'd1);
    end

    // Single requester 2 then drop
    req = 4'b0100; c = 1'b1;
    tick();
    chk("c_gnt", gnt, 4'b0100);
    chk("c_sel", {2'b0, sel}, 4'd2);
    chk("c_y", {3'b0, y}, 4'd1);
    req = 4'b0000;
    tick();
    chk("idle_busy", {3'b0, busy}, 4'd0);
    chk("idle_y", {3'b0, y}, 4'd0);
    chk("idle_sel", {2'b0, sel}, 4'd2);

    // Owner 1 releases while 0 and 3 wait: scan from 2 finds 3
    req = 4'b0010;
    tick(); tick();
    chk("own1", gnt, 4'b0010);
    req = 4'b1001;
    tick();
    chk("after1", gnt, 4'b1000);

    // Sole requester 2 keeps the grant
    req = 4'b0100;
    tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("sole", gnt, 4'b0100);
    end

    // Reset mid-grant with owner 3
    req = 4'b1000;
    tick();
    chk("own3", gnt, 4'b1000);
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt", gnt, 4'b0000);
    chk("mid_rst_sel", {2'b0, sel}, 4'd0);
    rst = 1'b0; req = 4'b1010;
    tick();
    chk("post_rst", gnt, 4'b0010);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 3) != 0) req = 4'($urandom);
      {d, c, b, a} = 4'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the team's 4:1 single-bit multiplexer datapath. Four requesters each present a request and a data bit (a, b, c, d). The block grants the shared mux to one requester at a time, drives the 2-bit select, and forwards the granted requester's bit to y. It sits directly in front of the mux and owns its select line, so no other logic drives sel.

## Interface
- MAX_HOLD, default 4: maximum consecutive cycles one requester keeps the grant while others wait; legal range 1..255.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  4  request per requester; bit i belongs to requester i.
- a, b, c, d  input  1 each  data bits of requesters 0..3.
- lock  input  1  present only with MUX4_ARB_LOCK_EN; see Configuration.
- gnt  output  4  one-hot grant, registered; all-zero when no grant.
- sel  output  2  registered mux select, equal to the index of the granted requester.
- y  output  1  combinational; the selected data bit when busy=1, otherwise 0.
- busy  output  1  registered; 1 while a grant is held.

## Operation
- Two-state FSM: IDLE and GRANT. Registers: owner (2b), last (2b) and hold_cnt.
- Reset values: state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, last=2'b11, hold_cnt=0, and therefore y=0. Setting last=2'b11 gives requester 0 top priority after reset.
- Round-robin pick: scan indices last+1, last+2, last+3, last+4 (mod 4); the first one with req=1 wins.
- In IDLE with req!=0: go to GRANT. Set owner=pick, gnt=1<<pick, sel=pick, busy=1, hold_cnt=1, last=pick.
- In IDLE with req=0: stay in IDLE. All outputs keep their IDLE values, and sel keeps its last value.
- In GRANT, the owner releases the grant when either:
  - req[owner]=0, or
  - hold_cnt==MAX_HOLD and another bit of req is set.
- On release with other requests pending: re-grant on the same edge, with no idle cycle. The pick starts from owner+1, and hold_cnt is reset to 1.
- On release with no requests pending: return to IDLE. gnt=0, busy=0, sel is retained.
- Otherwise the grant is held. hold_cnt increments and saturates at MAX_HOLD. A sole requester therefore keeps the grant indefinitely.
- hold_cnt is $clog2(MAX_HOLD+1) bits wide. It never wraps.
- y = busy ? {d,c,b,a}[sel] : 0. Data is not registered.

## Timing
- Grant latency: req rises before edge N, so gnt, sel and busy are valid after edge N. That is 1 cycle.
- Release: if req[owner] falls before edge N, the new grant (or IDLE) is visible after edge N.
- Timeout: the owner holds the grant for exactly MAX_HOLD cycles when contended. The switch happens at the edge where hold_cnt==MAX_HOLD is sampled.
- Simultaneous requests: the round-robin order alone decides the winner. A requester rising on the same edge as a release competes normally.
- Reset takes effect mid-grant: after the reset edge all outputs return to their reset values, and the next grant again favours requester 0.
- y follows data changes combinationally within the cycle. It changes only when sel or busy changes, or when the selected input changes.

## Configuration
- Macro: MUX4_ARB_LOCK_EN.
- Defined:
  - The lock port exists.
  - While busy=1 and lock=1, the MAX_HOLD timeout is suppressed; the grant is released only when req[owner] falls.
  - lock is ignored in IDLE.
  - hold_cnt still saturates.
- Undefined: no lock port, and the timeout always applies.

## Structure
- Package mux4_arb_pkg holds:
  - NUM_REQ=4 and SEL_W=2
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - typedef logic [SEL_W-1:0] sel_t
- Sub-module rr_pick4 is combinational. Inputs: req[3:0] and start index. Outputs: winner index and any_req. It is used both for the IDLE pick and for the re-pick on release.

## Test plan
- Reset, then req=4'b1111 with MAX_HOLD=4 → owners 0,1,2,3,0 in turn, each holding for 4 cycles; sel=0,1,2,3,0; busy stays 1 with no gap.
- req=4'b0100, c=1 → one cycle later gnt=4'b0100, sel=2'b10, y=1; drop req → next cycle busy=0, y=0, sel stays 2'b10.
- Owner 1 holds, req[1] falls while req=4'b1001 → next grant goes to requester 3 (scan from 2), gnt=4'b1000, hold_cnt=1.
- Only req[2]=1 for 20 cycles with MAX_HOLD=4 → gnt=4'b0100 for all 20 cycles, no re-grant glitch.
- rst=1 while owner=3 → next edge gnt=0, sel=0, busy=0; after rst=0 with req=4'b1010 → grant goes to requester 1.
- With MUX4_ARB_LOCK_EN: owner 0, lock=1, req=4'b0011 for 10 cycles → requester 0 holds all 10; lock=0 → switch to requester 1 at the next edge.
